execute_stage: RTL and testbench

- Execute stage of the five-stage pipeline; consumes the decode-to-execute register outputs.
- Performs operand forwarding, ALU operations, and branch/jump resolution.
- Drives the PC redirect (pcJump, pcIncrementOrJump) back to fetch.
- Contains the execute-to-memory pipeline register (stall hold, flush bubble); the memory stage reads its outputs.

---
 rtl/execute_stage_if.sv | 70 +++++++
 rtl/execute_stage.sv | 180 ++++++++++++++++++
 tb/tb_execute_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Execute-stage bundle: decode-to-execute operands and control, the writeback
// bypass, the PC redirect and the execute-to-memory register outputs.
interface execute_stage_if #(
    parameter int XLEN = 32
);
    // Decode-to-execute register outputs
    logic [XLEN-1:0] pcIn;
    logic [XLEN-1:0] readData1In;
    logic [XLEN-1:0] readData2In;
    logic [XLEN-1:0] immediateValueIn;
    logic [4:0]      rs1In;
    logic [4:0]      rs2In;
    logic [4:0]      rdIn;
    logic [2:0]      func3In;
    logic [6:0]      func7In;
    logic            pcUpdateIn;
    logic            memoryReadEnableIn;
    logic            memoryWriteEnableIn;
    logic            registerWriteEnableIn;
    logic            pcAdderSrcIn;
    logic            writeBackFromMemoryOrAluIn;
    logic [1:0]      aluSrc1In;
    logic [1:0]      aluSrc2In;
    logic [2:0]      aluOperationIn;

    // Writeback bypass
    logic [4:0]      wbRd;
    logic            wbWriteEnable;
    logic [XLEN-1:0] wbData;

    // Redirect to fetch
    logic [XLEN-1:0] pcJump;
    logic            pcIncrementOrJump;

    // Execute-to-memory register
    logic [XLEN-1:0] aluResultOut;
    logic [XLEN-1:0] storeDataOut;
    logic [4:0]      rdOut;
    logic [2:0]      func3Out;
    logic            memoryReadEnableOut;
    logic            memoryWriteEnableOut;
    logic            registerWriteEnableOut;
    logic            writeBackFromMemoryOrAluOut;

    modport master (
        output pcIn, readData1In, readData2In, immediateValueIn,
               rs1In, rs2In, rdIn, func3In, func7In,
               pcUpdateIn, memoryReadEnableIn, memoryWriteEnableIn,
               registerWriteEnableIn, pcAdderSrcIn, writeBackFromMemoryOrAluIn,
               aluSrc1In, aluSrc2In, aluOperationIn,
               wbRd, wbWriteEnable, wbData,
        input  pcJump, pcIncrementOrJump,
               aluResultOut, storeDataOut, rdOut, func3Out,
               memoryReadEnableOut, memoryWriteEnableOut,
               registerWriteEnableOut, writeBackFromMemoryOrAluOut
    );

    modport slave (
        input  pcIn, readData1In, readData2In, immediateValueIn,
               rs1In, rs2In, rdIn, func3In, func7In,
               pcUpdateIn, memoryReadEnableIn, memoryWriteEnableIn,
               registerWriteEnableIn, pcAdderSrcIn, writeBackFromMemoryOrAluIn,
               aluSrc1In, aluSrc2In, aluOperationIn,
               wbRd, wbWriteEnable, wbData,
        output pcJump, pcIncrementOrJump,
               aluResultOut, storeDataOut, rdOut, func3Out,
               memoryReadEnableOut, memoryWriteEnableOut,
               registerWriteEnableOut, writeBackFromMemoryOrAluOut
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution with a
// same-cycle PC redirect, and the execute-to-memory pipeline register.
module execute_stage #(
    parameter int              XLEN              = 32,
    parameter logic [XLEN-1:0] RESET_PC_REDIRECT = '0
) (
    input logic            clock,
    input logic            reset,
    input logic            stall,
    input logic            flush,
    execute_stage_if.slave ex
);
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_RTYPE  = 3'b001,
        OP_ITYPE  = 3'b010,
        OP_BRANCH = 3'b011,
        OP_PASS_B = 3'b100
    } aluOpT;

    typedef struct packed {
        logic [XLEN-1:0] aluResult;
        logic [XLEN-1:0] storeData;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic            memoryReadEnable;
        logic            memoryWriteEnable;
        logic            registerWriteEnable;
        logic            writeBackFromMemoryOrAlu;
    } exMemT;

    exMemT exMem;
    exMemT exMemNext;

    logic [XLEN-1:0]    forwardA;
    logic [XLEN-1:0]    forwardB;
    logic [XLEN-1:0]    operandA;
    logic [XLEN-1:0]    operandB;
    logic [XLEN-1:0]    sum;
    logic [XLEN-1:0]    diff;
    logic               lessSigned;
    logic               lessUnsigned;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    aluResult;
    logic               branchCondition;
    logic [XLEN-1:0]    branchTarget;
    logic               redirect;
    aluOpT              aluOp;
    logic               exMemForwardable;
    logic               unusedBits;

    assign aluOp      = aluOpT'(ex.aluOperationIn);
    assign unusedBits = ^{ex.func7In[6], ex.func7In[4:0]};

    // A load result sitting in EX/MEM is not yet data; the hazard unit stalls instead.
    assign exMemForwardable = exMem.registerWriteEnable && !exMem.memoryReadEnable
                              && (exMem.rd != 5'd0);

    // NOTE: every variable written in an always_comb gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        forwardA = ex.readData1In;
        if (exMemForwardable && exMem.rd == ex.rs1In) begin
            forwardA = exMem.aluResult;
        end else if (ex.wbWriteEnable && ex.wbRd != 5'd0 && ex.wbRd == ex.rs1In) begin
            forwardA = ex.wbData;
        end
    end

    always_comb begin
        forwardB = ex.readData2In;
        if (exMemForwardable && exMem.rd == ex.rs2In) begin
            forwardB = exMem.aluResult;
        end else if (ex.wbWriteEnable && ex.wbRd != 5'd0 && ex.wbRd == ex.rs2In) begin
            forwardB = ex.wbData;
        end
    end

    always_comb begin
        case (ex.aluSrc1In)
            2'b00:   operandA = forwardA;
            2'b01:   operandA = ex.pcIn;
            default: operandA = '0;
        endcase
    end

    always_comb begin
        case (ex.aluSrc2In)
            2'b00:   operandB = forwardB;
            2'b01:   operandB = ex.immediateValueIn;
            2'b10:   operandB = XLEN'(4);
            default: operandB = '0;
        endcase
    end

    assign sum          = operandA + operandB;
    assign diff         = operandA - operandB;
    assign lessSigned   = $signed(operandA) < $signed(operandB);
    assign lessUnsigned = operandA < operandB;
    assign shamt        = operandB[SHAMT_W-1:0];

    always_comb begin
        aluResult       = '0;
        branchCondition = 1'b0;
        case (aluOp)
            OP_ADD: aluResult = sum;
            OP_RTYPE, OP_ITYPE: begin
                case (ex.func3In)
                    3'b000:  aluResult = (aluOp == OP_RTYPE && ex.func7In[5]) ? diff : sum;
                    3'b001:  aluResult = operandA << shamt;
                    3'b010:  aluResult = {{(XLEN-1){1'b0}}, lessSigned};
                    3'b011:  aluResult = {{(XLEN-1){1'b0}}, lessUnsigned};
                    3'b100:  aluResult = operandA ^ operandB;
                    3'b101:  aluResult = ex.func7In[5] ? XLEN'($signed(operandA) >>> shamt)
                                                       : operandA >> shamt;
                    3'b110:  aluResult = operandA | operandB;
                    default: aluResult = operandA & operandB;
                endcase
            end
            OP_BRANCH: begin
                aluResult = diff;
                case (ex.func3In)
                    3'b000:  branchCondition = (diff == '0);
                    3'b001:  branchCondition = (diff != '0);
                    3'b100:  branchCondition = lessSigned;
                    3'b101:  branchCondition = !lessSigned;
                    3'b110:  branchCondition = lessUnsigned;
                    3'b111:  branchCondition = !lessUnsigned;
                    default: branchCondition = 1'b0;
                endcase
            end
            OP_PASS_B: aluResult = operandB;
            default:   aluResult = '0;
        endcase
    end

    // JALR clears bit 0 of the register-relative target.
    assign branchTarget = ex.pcAdderSrcIn
                        ? ((forwardA + ex.immediateValueIn) & {{(XLEN-1){1'b1}}, 1'b0})
                        : (ex.pcIn + ex.immediateValueIn);

    assign redirect = ex.pcUpdateIn && (aluOp != OP_BRANCH || branchCondition)
                      && !stall && !reset;

    assign ex.pcIncrementOrJump = redirect;
    assign ex.pcJump            = redirect ? branchTarget : RESET_PC_REDIRECT;

    always_comb begin
        exMemNext                          = '0;
        exMemNext.aluResult                = aluResult;
        exMemNext.storeData                = forwardB;
        exMemNext.rd                       = ex.rdIn;
        exMemNext.func3                    = ex.func3In;
        exMemNext.memoryReadEnable         = ex.memoryReadEnableIn;
        exMemNext.memoryWriteEnable        = ex.memoryWriteEnableIn;
        exMemNext.registerWriteEnable      = ex.registerWriteEnableIn && (ex.rdIn != 5'd0);
        exMemNext.writeBackFromMemoryOrAlu = ex.writeBackFromMemoryOrAluIn;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            exMem <= '0;
        end else if (flush) begin
            exMem <= '0;
        end else if (!stall) begin
            exMem <= exMemNext;
        end
    end

    assign ex.aluResultOut                = exMem.aluResult;
    assign ex.storeDataOut                = exMem.storeData;
    assign ex.rdOut                       = exMem.rd;
    assign ex.func3Out                    = exMem.func3;
    assign ex.memoryReadEnableOut         = exMem.memoryReadEnable;
    assign ex.memoryWriteEnableOut        = exMem.memoryWriteEnable;
    assign ex.registerWriteEnableOut      = exMem.registerWriteEnable;
    assign ex.writeBackFromMemoryOrAluOut = exMem.writeBackFromMemoryOrAlu;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by
// randomized traffic compared against a behavioural pipeline model.
module tb_execute_stage;
    logic clock;
    logic reset;
    logic stall;
    logic flush;

    execute_stage_if #(.XLEN(32)) bus ();

    execute_stage #(.XLEN(32), .RESET_PC_REDIRECT(32'h0)) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .ex   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        wbSel;
    } stageT;

    stageT model;
    stageT modelNext;
    int    checkCount = 0;
    int    passCount  = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("FAIL %s: got %h, want %h", tag, observed, expected);
    endtask

    function automatic logic [31:0] forwarded(input logic [4:0] rs, input logic [31:0] regValue);
        if (rs != 0 && model.regWrite && !model.memRead && model.rd == rs) return model.alu;
        if (rs != 0 && bus.wbWriteEnable && bus.wbRd == rs) return bus.wbData;
        return regValue;
    endfunction

    function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        int unsigned sh = b % 32;
        logic [31:0] fill;
        case (op)
            3'd0: return a + b;
            3'd1, 3'd2: begin
                case (f3)
                    3'd0: return (op == 3'd1 && f7[5]) ? a - b : a + b;
                    3'd1: return a << sh;
                    3'd2: return (sa < sb) ? 32'd1 : 32'd0;
                    3'd3: return (a < b) ? 32'd1 : 32'd0;
                    3'd4: return a ^ b;
                    3'd5: begin
                        fill = (sa < 0 && f7[5]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                        return (a >> sh) | fill;
                    end
                    3'd6: return a | b;
                    default: return a & b;
                endcase
            end
            3'd3: return a - b;
            3'd4: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic branchRef(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Checks the same-cycle redirect and works out what the register should capture.
    task automatic settle();
        logic [31:0] fa, fb, a, b, target, expJump;
        logic        cond, expRedirect;
        #1;
        fa = forwarded(bus.rs1In, bus.readData1In);
        fb = forwarded(bus.rs2In, bus.readData2In);
        a  = (bus.aluSrc1In == 2'd0) ? fa : (bus.aluSrc1In == 2'd1) ? bus.pcIn : 32'd0;
        case (bus.aluSrc2In)
            2'd0:    b = fb;
            2'd1:    b = bus.immediateValueIn;
            2'd2:    b = 32'd4;
            default: b = 32'd0;
        endcase
        cond        = (bus.aluOperationIn == 3'd3) ? branchRef(bus.func3In, a, b) : 1'b1;
        expRedirect = bus.pcUpdateIn && cond && !stall && !reset;
        target      = bus.pcAdderSrcIn ? ((fa + bus.immediateValueIn) & 32'hFFFF_FFFE)
                                       : bus.pcIn + bus.immediateValueIn;
        expJump     = expRedirect ? target : 32'd0;
        check("redirect", {31'd0, bus.pcIncrementOrJump}, {31'd0, expRedirect});
        check("pcJump", bus.pcJump, expJump);

        if (reset || flush) begin
            modelNext = '{default: '0};
        end else if (stall) begin
            modelNext = model;
        end else begin
            modelNext.alu      = aluRef(bus.aluOperationIn, bus.func3In, bus.func7In, a, b);
            modelNext.store    = fb;
            modelNext.rd       = bus.rdIn;
            modelNext.f3       = bus.func3In;
            modelNext.memRead  = bus.memoryReadEnableIn;
            modelNext.memWrite = bus.memoryWriteEnableIn;
            modelNext.regWrite = bus.registerWriteEnableIn && bus.rdIn != 0;
            modelNext.wbSel    = bus.writeBackFromMemoryOrAluIn;
        end
    endtask

    task automatic clockEdge();
        @(posedge clock);
        model = modelNext;
        @(negedge clock);
        check("aluResultOut", bus.aluResultOut, model.alu);
        check("storeDataOut", bus.storeDataOut, model.store);
        check("rdOut", {27'd0, bus.rdOut}, {27'd0, model.rd});
        check("func3Out", {29'd0, bus.func3Out}, {29'd0, model.f3});
        check("enables", {28'd0, bus.memoryReadEnableOut, bus.memoryWriteEnableOut,
                          bus.registerWriteEnableOut, bus.writeBackFromMemoryOrAluOut},
                         {28'd0, model.memRead, model.memWrite, model.regWrite, model.wbSel});
    endtask

    task automatic step();
        settle();
        clockEdge();
    endtask

    task automatic clearInputs();
        reset = 0; stall = 0; flush = 0;
        bus.pcIn = 0; bus.readData1In = 0; bus.readData2In = 0; bus.immediateValueIn = 0;
        bus.rs1In = 0; bus.rs2In = 0; bus.rdIn = 0; bus.func3In = 0; bus.func7In = 0;
        bus.pcUpdateIn = 0; bus.memoryReadEnableIn = 0; bus.memoryWriteEnableIn = 0;
        bus.registerWriteEnableIn = 0; bus.pcAdderSrcIn = 0; bus.writeBackFromMemoryOrAluIn = 0;
        bus.aluSrc1In = 0; bus.aluSrc2In = 0; bus.aluOperationIn = 0;
        bus.wbRd = 0; bus.wbWriteEnable = 0; bus.wbData = 0;
    endtask

    task automatic randomInputs();
        bus.pcIn = $urandom & 32'hFFFF_FFFC;
        bus.readData1In = $urandom; bus.readData2In = $urandom;
        bus.immediateValueIn = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        bus.rs1In = 5'($urandom_range(0, 7)); bus.rs2In = 5'($urandom_range(0, 7));
        bus.rdIn = 5'($urandom_range(0, 7));
        bus.func3In = 3'($urandom); bus.func7In = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
        bus.pcUpdateIn = 1'($urandom); bus.memoryReadEnableIn = ($urandom_range(0, 3) == 0);
        bus.memoryWriteEnableIn = 1'($urandom); bus.registerWriteEnableIn = ($urandom_range(0, 3) != 0);
        bus.pcAdderSrcIn = 1'($urandom); bus.writeBackFromMemoryOrAluIn = 1'($urandom);
        bus.aluSrc1In = 2'($urandom); bus.aluSrc2In = 2'($urandom);
        bus.aluOperationIn = 3'($urandom_range(0, 7));
        bus.wbRd = 5'($urandom_range(0, 7)); bus.wbWriteEnable = 1'($urandom); bus.wbData = $urandom;
    endtask

    initial begin
        model = '{default: '0};
        clearInputs();

        // Reset
        reset = 1;
        step();
        check("reset alu", bus.aluResultOut, 32'd0);
        reset = 0;

        // ADD x3, x1, x2
        bus.rs1In = 1; bus.rs2In = 2; bus.rdIn = 3; bus.readData1In = 5; bus.readData2In = 7;
        bus.aluOperationIn = 3'b001; bus.registerWriteEnableIn = 1;
        step();
        check("add result", bus.aluResultOut, 32'd12);
        check("add rd", {27'd0, bus.rdOut}, 32'd3);
        check("add regWrite", {31'd0, bus.registerWriteEnableOut}, 32'd1);

        // EX/MEM beats WB, then WB wins when EX/MEM targets x0
        for (int pass = 0; pass < 2; pass++) begin
            clearInputs();
            bus.rdIn = (pass == 0) ? 5'd5 : 5'd0; bus.registerWriteEnableIn = 1;
            bus.aluOperationIn = 3'b100; bus.aluSrc2In = 2'b01; bus.immediateValueIn = 32'h10;
            step();
            clearInputs();
            bus.rs1In = 5; bus.rs2In = 0; bus.rdIn = 6; bus.readData1In = 32'h77;
            bus.aluOperationIn = 3'b001; bus.registerWriteEnableIn = 1;
            bus.wbRd = 5; bus.wbWriteEnable = 1; bus.wbData = 32'h99;
            step();
            check(pass == 0 ? "fwd exmem" : "fwd wb", bus.aluResultOut, pass == 0 ? 32'h10 : 32'h99);
        end

        // BLT taken, BLTU not taken
        clearInputs();
        bus.pcIn = 32'h40; bus.immediateValueIn = -32'sd8; bus.rs1In = 1; bus.rs2In = 2;
        bus.readData1In = 32'hFFFF_FFFF; bus.readData2In = 1;
        bus.aluOperationIn = 3'b011; bus.func3In = 3'b100; bus.pcUpdateIn = 1;
        settle();
        check("blt redirect", {31'd0, bus.pcIncrementOrJump}, 32'd1);
        check("blt target", bus.pcJump, 32'h38);
        clockEdge();
        bus.func3In = 3'b110;
        settle();
        check("bltu redirect", {31'd0, bus.pcIncrementOrJump}, 32'd0);
        check("bltu target", bus.pcJump, 32'd0);
        clockEdge();

        // JALR
        clearInputs();
        bus.pcIn = 32'h200; bus.rs1In = 1; bus.readData1In = 32'h1001; bus.immediateValueIn = 4;
        bus.pcAdderSrcIn = 1; bus.aluSrc1In = 2'b01; bus.aluSrc2In = 2'b10; bus.pcUpdateIn = 1;
        bus.rdIn = 1; bus.registerWriteEnableIn = 1;
        settle();
        check("jalr target", bus.pcJump, 32'h1004);
        clockEdge();
        check("jalr link", bus.aluResultOut, 32'h204);

        // Stall holds the register and suppresses redirects
        for (int i = 0; i < 3; i++) begin
            randomInputs();
            bus.pcUpdateIn = 1; bus.aluOperationIn = 3'b000;
            stall = 1;
            settle();
            check("stall redirect", {31'd0, bus.pcIncrementOrJump}, 32'd0);
            clockEdge();
            check("stall hold", bus.aluResultOut, 32'h204);
        end

        // Flush beats stall
        randomInputs();
        bus.registerWriteEnableIn = 1; bus.rdIn = 4; bus.memoryWriteEnableIn = 1;
        stall = 1; flush = 1;
        step();
        check("flush enables", {28'd0, bus.memoryReadEnableOut, bus.memoryWriteEnableOut,
                                bus.registerWriteEnableOut, bus.writeBackFromMemoryOrAluOut}, 32'd0);

        // Write to x0 is dropped
        clearInputs();
        bus.rdIn = 0; bus.registerWriteEnableIn = 1; bus.aluSrc2In = 2'b01; bus.immediateValueIn = 9;
        step();
        check("x0 regWrite", {31'd0, bus.registerWriteEnableOut}, 32'd0);

        // Reset mid-stall
        clearInputs();
        bus.rdIn = 7; bus.registerWriteEnableIn = 1; bus.aluSrc2In = 2'b01; bus.immediateValueIn = 32'h55;
        step();
        stall = 1; reset = 1;
        step();
        check("reset mid-stall", bus.aluResultOut, 32'd0);
        check("reset rd", {27'd0, bus.rdOut}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            randomInputs();
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
